// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the cache port arbiter
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic M_INSTR = 1'b0;
  localparam logic M_DATA  = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational 2-way round-robin winner select
module rr_arb2
  import cache_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  // A lone requester always wins; on a tie the master that did not win last time goes first.
  always_comb begin
    valid  = |req;
    winner = M_INSTR;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = M_DATA;
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - shares the cache core port between instruction fetch and LSU
module cache_port_arbiter
  import cache_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_error_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_error_o,
  output logic        s_req_o,
  output logic [31:0] s_addr_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,
  input  logic        s_error_i,
  output logic        busy_o
);

  state_t           state;
  logic             owner;
  logic             last;
  req_t             lat;
  logic [CNT_W-1:0] count;

  logic             win;
  logic             win_valid;
  logic             grant;
  req_t             cand;
  logic             tmo_hit;
  logic             resp_valid;
  logic [31:0]      resp_data;
  logic             resp_err;

  rr_arb2 u_arb (
    .req    ({m1_req_i, m0_req_i}),
    .last   (last),
    .winner (win),
    .valid  (win_valid)
  );

  // Grant is only offered from IDLE, which also keeps it low while reset is held.
  always_comb begin
    grant    = (state == IDLE) && win_valid && !reset;
    m0_gnt_o = grant && (win == M_INSTR);
    m1_gnt_o = grant && (win == M_DATA);
    if (win == M_DATA) cand = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};
    else               cand = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
  end

  // Response path: a real cache response wins over the watchdog; only the owner ever sees it.
  always_comb begin
    tmo_hit     = (TIMEOUT_CYCLES != 0) && (count == CNT_W'(TIMEOUT_CYCLES - 1));
    resp_valid  = (state == WAIT) && (s_rvalid_i || tmo_hit);
    resp_data   = s_rvalid_i ? s_rdata_i : 32'h0;
    resp_err    = s_rvalid_i ? s_error_i : 1'b1;
    m0_rvalid_o = resp_valid && (owner == M_INSTR);
    m1_rvalid_o = resp_valid && (owner == M_DATA);
    m0_rdata_o  = m0_rvalid_o ? resp_data : 32'h0;
    m1_rdata_o  = m1_rvalid_o ? resp_data : 32'h0;
    m0_error_o  = m0_rvalid_o && resp_err;
    m1_error_o  = m1_rvalid_o && resp_err;
  end

  assign s_req_o   = (state == ISSUE);
  assign s_addr_o  = lat.addr;
  assign s_we_o    = lat.we;
  assign s_be_o    = lat.be;
  assign s_wdata_o = lat.wdata;
  assign busy_o    = (state != IDLE);

  // Transaction FSM: latch winner, present to cache, wait for response or watchdog expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= M_INSTR;
      last  <= M_DATA;
      lat   <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            lat   <= cand;
            owner <= win;
            last  <= win;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (s_gnt_i) begin
            count <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          count <= count + 1'b1;
          if (resp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - directed scoreboard bench for cache_port_arbiter
module tb_cache_port_arbiter;

  logic clk = 1'b0;
  logic reset, reset_t;
  logic m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0] m0_be, m1_be;
  logic s_gnt, s_rvalid, s_error, s_gnt_t, s_rvalid_t;
  logic [31:0] s_rdata;

  logic m0_gnt_o, m0_rvalid_o, m0_error_o, m1_gnt_o, m1_rvalid_o, m1_error_o;
  logic [31:0] m0_rdata_o, m1_rdata_o, s_addr_o, s_wdata_o;
  logic s_req_o, s_we_o, busy_o;
  logic [3:0] s_be_o;

  logic t_m0_gnt, t_m0_rvalid, t_m0_error, t_m1_gnt, t_m1_rvalid, t_m1_error;
  logic [31:0] t_m0_rdata, t_m1_rdata, t_s_addr, t_s_wdata;
  logic t_s_req, t_s_we, t_busy;
  logic [3:0] t_s_be;

  typedef struct {
    logic        m;
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_port_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_error_o(m0_error_o),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_error_o(m1_error_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_error_i(s_error),
    .busy_o(busy_o)
  );

  cache_port_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut_t (
    .clk(clk), .reset(reset_t),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(t_m0_gnt), .m0_rvalid_o(t_m0_rvalid), .m0_rdata_o(t_m0_rdata), .m0_error_o(t_m0_error),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(t_m1_gnt), .m1_rvalid_o(t_m1_rvalid), .m1_rdata_o(t_m1_rdata), .m1_error_o(t_m1_error),
    .s_req_o(t_s_req), .s_addr_o(t_s_addr), .s_we_o(t_s_we), .s_be_o(t_s_be), .s_wdata_o(t_s_wdata),
    .s_gnt_i(s_gnt_t), .s_rvalid_i(s_rvalid_t), .s_rdata_i(s_rdata), .s_error_i(s_error),
    .busy_o(t_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_resp(input string tag, input logic v0, input logic v1,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic e0, input logic e1);
    exp_t x;
    if (sb.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'd0, 32'd1);
      return;
    end
    x = sb.pop_front();
    chk({tag, "_owner_rvalid"}, x.m ? v1 : v0, 32'd1);
    chk({tag, "_other_rvalid"}, x.m ? v0 : v1, 32'd0);
    chk({tag, "_owner_rdata"},  x.m ? d1 : d0, x.d);
    chk({tag, "_other_rdata"},  x.m ? d0 : d1, 32'd0);
    chk({tag, "_owner_error"},  x.m ? e1 : e0, {31'd0, x.e});
    chk({tag, "_other_error"},  x.m ? e0 : e1, 32'd0);
  endtask

  // Entered in the grant cycle of master gm; leaves the arbiter in the following IDLE cycle.
  task automatic serve(input logic gm, input int stall, input int lat, input logic [31:0] rd,
                       input logic er, input logic raise_other);
    logic [31:0] ea, ew;
    logic        ewe;
    logic [3:0]  ebe;
    ea  = gm ? m1_addr : m0_addr;
    ew  = gm ? m1_wdata : m0_wdata;
    ewe = gm ? m1_we : m0_we;
    ebe = gm ? m1_be : m0_be;
    sb.push_back('{m: gm, d: rd, e: er});
    tick();
    if (gm) m1_req = 1'b0; else m0_req = 1'b0;
    if (raise_other) begin
      if (gm) m0_req = 1'b1; else m1_req = 1'b1;
    end
    for (int k = 0; k <= stall; k++) begin
      s_gnt = (k == stall);
      settle();
      chk("issue_s_req", s_req_o, 32'd1);
      chk("issue_s_addr", s_addr_o, ea);
      chk("issue_s_we", s_we_o, {31'd0, ewe});
      chk("issue_s_be", s_be_o, {28'd0, ebe});
      chk("issue_s_wdata", s_wdata_o, ew);
      chk("issue_no_gnt", {m1_gnt_o, m0_gnt_o}, 32'd0);
      tick();
    end
    s_gnt = 1'b1;
    for (int j = 1; j < lat; j++) begin
      settle();
      chk("wait_s_req", s_req_o, 32'd0);
      chk("wait_no_rvalid", {m1_rvalid_o, m0_rvalid_o}, 32'd0);
      chk("wait_no_gnt", {m1_gnt_o, m0_gnt_o}, 32'd0);
      chk("wait_busy", busy_o, 32'd1);
      tick();
    end
    s_rvalid = 1'b1;
    s_rdata  = rd;
    s_error  = er;
    settle();
    check_resp("resp", m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o, m0_error_o, m1_error_o);
    chk("resp_no_gnt", {m1_gnt_o, m0_gnt_o}, 32'd0);
    tick();
    s_rvalid = 1'b0;
    s_error  = 1'b0;
    s_rdata  = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; reset_t = 1'b1;
    m0_req = 0; m0_addr = 0; m0_we = 0; m0_be = 0; m0_wdata = 0;
    m1_req = 0; m1_addr = 0; m1_we = 0; m1_be = 0; m1_wdata = 0;
    s_gnt = 1; s_rvalid = 0; s_rdata = 0; s_error = 0; s_gnt_t = 1; s_rvalid_t = 0;
    tick(); tick();
    m0_req = 1'b1;
    settle();
    chk("rst_gnt", {m1_gnt_o, m0_gnt_o}, 32'd0);
    chk("rst_busy", busy_o, 32'd0);
    chk("rst_s_req", s_req_o, 32'd0);
    chk("rst_s_fields", s_addr_o | s_wdata_o | {27'd0, s_we_o, s_be_o}, 32'd0);
    chk("rst_rvalid", {m1_rvalid_o, m0_rvalid_o, m1_error_o, m0_error_o}, 32'd0);
    chk("rst_rdata", m0_rdata_o | m1_rdata_o, 32'd0);
    m0_req = 1'b0;
    tick();
    reset = 1'b0;

    // single read from the instruction port
    tick();
    m0_addr = 32'h0000_0104; m0_be = 4'hF; m0_req = 1'b1;
    settle();
    chk("t1_gnt", {m1_gnt_o, m0_gnt_o}, 32'b01);
    chk("t1_busy_idle", busy_o, 32'd0);
    serve(1'b0, 0, 6, 32'hDEAD_BEEF, 1'b0, 1'b0);
    settle();
    chk("t1_idle_busy", busy_o, 32'd0);

    // tie after reset, then keep both requesting
    reset = 1'b1; tick(); reset = 1'b0; tick();
    m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000; m1_be = 4'hF;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      logic wm;
      wm = g[0];
      settle();
      chk("tie_gnt", {m1_gnt_o, m0_gnt_o}, wm ? 32'b10 : 32'b01);
      serve(wm, 0, 2 + g, 32'h0000_0100 + g, 1'b0, 1'b0);
      if (wm) m1_req = 1'b1; else m0_req = 1'b1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    // write passthrough on the data port with an error response
    m1_addr = 32'h0000_0200; m1_we = 1'b1; m1_be = 4'b0011; m1_wdata = 32'h1234_5678; m1_req = 1'b1;
    settle();
    chk("wr_gnt", {m1_gnt_o, m0_gnt_o}, 32'b10);
    serve(1'b1, 0, 2, 32'hA5A5_A5A5, 1'b1, 1'b0);
    m1_we = 1'b0; m1_wdata = 32'h0;

    // stalled cache grant while the other master waits
    m1_addr = 32'h0000_0300; m1_be = 4'hF; m1_req = 1'b1;
    m0_addr = 32'h0000_0400; m0_be = 4'b1100;
    settle();
    chk("stall_gnt", {m1_gnt_o, m0_gnt_o}, 32'b10);
    serve(1'b1, 3, 3, 32'h0BAD_F00D, 1'b0, 1'b1);
    settle();
    chk("stall_next_gnt", {m1_gnt_o, m0_gnt_o}, 32'b01);
    serve(1'b0, 0, 1, 32'h4444_4444, 1'b0, 1'b0);

    // watchdog on the short-timeout instance, then a late response
    reset = 1'b1; reset_t = 1'b0;
    tick();
    s_rdata = 32'hFFFF_FFFF;
    m0_addr = 32'h0000_0500; m0_req = 1'b1;
    settle();
    chk("to_gnt", {t_m1_gnt, t_m0_gnt}, 32'b01);
    sb.push_back('{m: 1'b0, d: 32'h0, e: 1'b1});
    tick();
    m0_req = 1'b0;
    settle();
    chk("to_s_req", t_s_req, 32'd1);
    tick();
    for (int w = 1; w < 4; w++) begin
      settle();
      chk("to_wait_no_rvalid", {t_m1_rvalid, t_m0_rvalid}, 32'd0);
      tick();
    end
    settle();
    check_resp("timeout", t_m0_rvalid, t_m1_rvalid, t_m0_rdata, t_m1_rdata, t_m0_error, t_m1_error);
    tick();
    tick();
    s_rvalid_t = 1'b1;
    settle();
    chk("late_no_rvalid", {t_m1_rvalid, t_m0_rvalid, t_m1_error, t_m0_error}, 32'd0);
    chk("late_no_rdata", t_m0_rdata | t_m1_rdata, 32'd0);
    chk("late_idle", t_busy, 32'd0);
    tick();
    s_rvalid_t = 1'b0; s_rdata = 32'h0; reset_t = 1'b1;

    // asynchronous reset in the middle of WAIT
    reset = 1'b0;
    tick();
    m0_addr = 32'h0000_0600; m0_req = 1'b1;
    settle();
    chk("ar_gnt", {m1_gnt_o, m0_gnt_o}, 32'b01);
    tick();
    m0_req = 1'b0;
    tick();
    settle();
    chk("ar_busy_wait", busy_o, 32'd1);
    m0_req = 1'b1; m1_req = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h77;
    #1;
    reset = 1'b1;
    #1;
    chk("ar_busy", busy_o, 32'd0);
    chk("ar_s_req", s_req_o, 32'd0);
    chk("ar_gnt_low", {m1_gnt_o, m0_gnt_o}, 32'd0);
    chk("ar_rvalid_low", {m1_rvalid_o, m0_rvalid_o}, 32'd0);
    chk("ar_rdata_low", m0_rdata_o | m1_rdata_o, 32'd0);
    tick();
    s_rvalid = 1'b0; s_rdata = 32'h0;
    reset = 1'b0;
    settle();
    chk("ar_tie_gnt", {m1_gnt_o, m0_gnt_o}, 32'b01);
    m0_req = 1'b0; m1_req = 1'b0;
    reset = 1'b1;
    tick();

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
